// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin sharing of one FPU among REQUESTERS clients, one operation in flight.
// Define FPU_ARB_TIMEOUT_EN to add a watchdog on the FPU wait (error response after TIMEOUT_CYCLES).
module fpu_arbiter #(
  parameter int bitness        = 32,
  parameter int REQUESTERS     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [REQUESTERS-1:0]         req_valid,
  output logic [REQUESTERS-1:0]         req_ready,
  input  logic [REQUESTERS*bitness-1:0] req_data_a,
  input  logic [REQUESTERS*bitness-1:0] req_data_b,
  input  logic [REQUESTERS*4-1:0]       req_operation,
  output logic [REQUESTERS-1:0]         resp_valid,
  input  logic [REQUESTERS-1:0]         resp_ack,
  output logic [bitness-1:0]            resp_result,
  output logic                          resp_error,
  output logic                          fpu_input_rdy,
  output logic [bitness-1:0]            fpu_data_a,
  output logic [bitness-1:0]            fpu_data_b,
  output logic [3:0]                    fpu_operation,
  input  logic                          fpu_output_rdy,
  output logic                          fpu_output_ack,
  input  logic [bitness-1:0]            fpu_result
);
  localparam int PW = $clog2(REQUESTERS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state;
  logic [PW-1:0]           rr_ptr;
  logic [PW-1:0]           grant;
  logic [REQUESTERS-1:0]   grant_oh;

  logic                    grant_found;
  logic [PW-1:0]           grant_idx;
  logic [REQUESTERS-1:0]   grant_onehot;
  logic [bitness-1:0]      sel_a;
  logic [bitness-1:0]      sel_b;
  logic [3:0]              sel_op;

  // Scan offsets from the farthest to the nearest so the requester closest to rr_ptr wins.
  always_comb begin
    grant_found  = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    sel_a        = '0;
    sel_b        = '0;
    sel_op       = '0;
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      for (int j = 0; j < REQUESTERS; j++) begin
        if (req_valid[j] && (((int'(rr_ptr) + i) % REQUESTERS) == j)) begin
          grant_found     = 1'b1;
          grant_idx       = PW'(j);
          grant_onehot    = '0;
          grant_onehot[j] = 1'b1;
          sel_a           = req_data_a[j*bitness +: bitness];
          sel_b           = req_data_b[j*bitness +: bitness];
          sel_op          = req_operation[j*4 +: 4];
        end
      end
    end
  end

`ifdef FPU_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt;
  // A result that shows up after the watchdog fired is still drained so the FPU is not left stuck.
  assign fpu_output_ack = fpu_output_rdy && (state == WAIT || state == IDLE);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign resp_error     = 1'b0;
  assign fpu_output_ack = fpu_output_rdy && (state == WAIT);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant         <= '0;
      grant_oh      <= '0;
      req_ready     <= '0;
      resp_valid    <= '0;
      resp_result   <= '0;
      fpu_input_rdy <= 1'b0;
      fpu_data_a    <= '0;
      fpu_data_b    <= '0;
      fpu_operation <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
      resp_error    <= 1'b0;
      wait_cnt      <= '0;
`endif
    end else begin
      req_ready     <= '0;
      fpu_input_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            grant         <= grant_idx;
            grant_oh      <= grant_onehot;
            fpu_data_a    <= sel_a;
            fpu_data_b    <= sel_b;
            fpu_operation <= sel_op;
            req_ready     <= grant_onehot;
            fpu_input_rdy <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (fpu_output_rdy) begin
            resp_result <= fpu_result;
            resp_valid  <= grant_oh;
            state       <= RESP;
`ifdef FPU_ARB_TIMEOUT_EN
            resp_error  <= 1'b0;
          end else if (wait_cnt + 16'd1 == 16'(TIMEOUT_CYCLES)) begin
            resp_result <= '1;
            resp_error  <= 1'b1;
            resp_valid  <= grant_oh;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
`endif
          end
        end
        RESP: begin
          if (|(resp_ack & grant_oh)) begin
            resp_valid <= '0;
            rr_ptr     <= (grant == PW'(REQUESTERS - 1)) ? '0 : grant + PW'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter with a latency-programmable FPU stub.
// Watchdog scenario is exercised only when FPU_ARB_TIMEOUT_EN is defined.
module tb_fpu_arbiter;
  localparam int W       = 32;
  localparam int N       = 4;
  localparam int TIMEOUT = 8;

  logic             clock;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_data_a;
  logic [N*W-1:0]   req_data_b;
  logic [N*4-1:0]   req_operation;
  logic [N-1:0]     resp_valid;
  logic [N-1:0]     resp_ack;
  logic [W-1:0]     resp_result;
  logic             resp_error;
  logic             fpu_input_rdy;
  logic [W-1:0]     fpu_data_a;
  logic [W-1:0]     fpu_data_b;
  logic [3:0]       fpu_operation;
  logic             fpu_output_rdy;
  logic             fpu_output_ack;
  logic [W-1:0]     fpu_result;

  fpu_arbiter #(.bitness(W), .REQUESTERS(N), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data_a(req_data_a), .req_data_b(req_data_b), .req_operation(req_operation),
    .resp_valid(resp_valid), .resp_ack(resp_ack), .resp_result(resp_result), .resp_error(resp_error),
    .fpu_input_rdy(fpu_input_rdy), .fpu_data_a(fpu_data_a), .fpu_data_b(fpu_data_b),
    .fpu_operation(fpu_operation), .fpu_output_rdy(fpu_output_rdy),
    .fpu_output_ack(fpu_output_ack), .fpu_result(fpu_result)
  );

  typedef struct {
    int          client;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   issue_cyc = 0;
  int   in_resp = 0;
  int   held = 0;
  int   ack_hold = 0;
  int   fpu_lat = 2;
  logic stub_dead = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    if (op == 4'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return (a + b) ^ {b[15:0], a[31:16]} ^ {28'd0, op};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // FPU stub: samples mid-cycle, acts just after the rising edge.
  initial begin
    logic        issued, acked;
    logic [31:0] pa, pb;
    logic [3:0]  pop;
    int          countdown;
    fpu_output_rdy = 1'b0;
    fpu_result     = '0;
    countdown      = 0;
    pa = '0; pb = '0; pop = '0;
    forever begin
      @(negedge clock);
      issued = fpu_input_rdy;
      acked  = fpu_output_rdy & fpu_output_ack;
      if (issued) begin
        pa = fpu_data_a; pb = fpu_data_b; pop = fpu_operation;
      end
      @(posedge clock); #1;
      if (reset) begin
        fpu_output_rdy = 1'b0;
        countdown      = 0;
      end else begin
        if (acked) fpu_output_rdy = 1'b0;
        if (issued) countdown = fpu_lat;
        else if (countdown > 0) begin
          countdown--;
          if (countdown == 0 && !stub_dead) begin
            fpu_output_rdy = 1'b1;
            fpu_result     = fpu_model(pa, pb, pop);
          end
        end
      end
    end
  end

  task automatic request(input int c, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    exp_t e;
    e.client = c; e.a = a; e.b = b; e.op = op;
    e.res = stub_dead ? 32'hFFFF_FFFF : fpu_model(a, b, op);
    e.err = stub_dead;
    e.lat = stub_dead ? TIMEOUT + 1 : fpu_lat + 2;
    req_data_a[c*W +: W]     = a;
    req_data_b[c*W +: W]     = b;
    req_operation[c*4 +: 4]  = op;
    req_valid[c]             = 1'b1;
    sb.push_back(e);
  endtask

  task automatic tick();
    logic [N-1:0] oh;
    @(posedge clock); #1;
    cyc++;
    check("strobe_matches_ready", fpu_input_rdy, |req_ready);
    if (req_ready != 0) begin
      check("ready_onehot", $onehot(req_ready), 1);
      check("no_grant_in_resp", resp_valid, 0);
      if (sb.size() == 0) check("unexpected_grant", req_ready, 0);
      else begin
        oh = '0; oh[sb[0].client] = 1'b1;
        check("grant", req_ready, oh);
        check("issue_a", fpu_data_a, sb[0].a);
        check("issue_b", fpu_data_b, sb[0].b);
        check("issue_op", fpu_operation, sb[0].op);
        issue_cyc = cyc;
        for (int i = 0; i < N; i++) if (req_ready[i]) req_valid[i] = 1'b0;
      end
    end
    if (resp_valid != 0) begin
      if (in_resp == 0) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", resp_valid, 0);
          resp_ack = resp_valid;
        end else begin
          cur = sb.pop_front();
          in_resp = 1;
          held = 0;
          check("resp_latency", cyc - issue_cyc, cur.lat);
          $display("resp client=%0d result=%08h error=%0b", cur.client, resp_result, resp_error);
        end
      end
      if (in_resp != 0) begin
        oh = '0; oh[cur.client] = 1'b1;
        check("resp_valid", resp_valid, oh);
        check("resp_result", resp_result, cur.res);
        check("resp_error", resp_error, cur.err);
        check("fpu_a_stable", fpu_data_a, cur.a);
        if (held >= ack_hold) resp_ack = oh;
        held++;
      end
    end else begin
      resp_ack = '0;
      in_resp = 0;
    end
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while ((sb.size() != 0 || in_resp != 0 || resp_valid != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_within_budget", n < budget, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_input_rdy"}, fpu_input_rdy, 0);
    check({tag, "_fpu_a"}, fpu_data_a, 0);
    check({tag, "_fpu_op"}, fpu_operation, 0);
    check({tag, "_resp_result"}, resp_result, 0);
    check({tag, "_resp_error"}, resp_error, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    req_valid = '0; req_data_a = '0; req_data_b = '0; req_operation = '0; resp_ack = '0;
    repeat (2) @(posedge clock);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;

    // Single client, add
    request(1, 32'h3F80_0000, 32'h4000_0000, 4'd0);
    tick();
    check("grant_latency", req_ready, 4'b0010);
    tick();
    check("issue_pulse_width", fpu_input_rdy, 0);
    run_until_done(50);

    // Reset while waiting on the FPU, then re-request
    fpu_lat = 20;
    request(2, 32'h1111_2222, 32'h3333_4444, 4'd1);
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    sb.delete(); in_resp = 0; resp_ack = '0; req_valid = '0;
    tick(); tick();
    reset = 1'b0;
    fpu_lat = 2;
    request(2, 32'h5555_6666, 32'h7777_8888, 4'd2);
    run_until_done(50);

    // Back to reset priority, all four clients contend
    reset = 1'b1;
    tick();
    check_idle_outputs("pulse_reset");
    reset = 1'b0;
    for (int c = 0; c < N; c++)
      request(c, 32'h1000_0001 * (c + 1), 32'h0F0F_0000 + 32'(c), 4'(c + 3));
    n = 0;
    while (req_valid[0] && n < 20) begin tick(); n++; end
    check("client0_granted", req_valid[0], 0);
    request(0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 4'd5);
    run_until_done(200);

    // rr_ptr lands on 3 after serving 2, so 3 beats 2
    request(2, 32'hAAAA_0002, 32'h0000_0022, 4'd6);
    run_until_done(50);
    request(3, 32'hBBBB_0003, 32'h0000_0033, 4'd7);
    request(2, 32'hCCCC_0002, 32'h0000_0044, 4'd8);
    run_until_done(100);

    // Hold responses unacknowledged with another client waiting
    ack_hold = 10;
    fpu_lat = 3;
    request(0, 32'h0123_4567, 32'h89AB_CDEF, 4'd9);
    request(1, 32'hFEDC_BA98, 32'h7654_3210, 4'd10);
    run_until_done(200);
    ack_hold = 0;

`ifdef FPU_ARB_TIMEOUT_EN
    stub_dead = 1'b1;
    request(0, 32'h4242_4242, 32'h2424_2424, 4'd1);
    run_until_done(100);
    stub_dead = 1'b0;
    request(3, 32'h3F80_0000, 32'h4000_0000, 4'd0);
    run_until_done(50);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
